// File: rtl/switch_led_axil_slave.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | switch_led_axil_slave: AXI4-Lite register slave driving LEDs from       |
// | software or from synchronised, debounced switches.  Rev 1.0             |
// +------------------------------------------------------------------------+
module switch_led_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_SW             = 4,
  parameter int NUM_LED            = 4,
  parameter int DEBOUNCE_CYCLES    = 1000000
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [NUM_SW-1:0]               sw_i,
  output logic [NUM_LED-1:0]              led_o
);

  localparam int                 c_cnt_w   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] c_w_idle = 2'd0;
  localparam logic [1:0] c_w_ack  = 2'd1;
  localparam logic [1:0] c_w_resp = 2'd2;
  localparam logic [1:0] c_r_idle = 2'd0;
  localparam logic [1:0] c_r_ack  = 2'd1;
  localparam logic [1:0] c_r_data = 2'd2;

  logic [1:0]         r_wstate, w_wstate_nxt;
  logic [1:0]         r_rstate, w_rstate_nxt;
  logic [NUM_LED-1:0] r_led;
  logic [1:0]         r_ctrl;
  logic [31:0]        r_scr;
  logic [31:0]        r_rdata;
  logic [NUM_LED-1:0] r_led_o;
  logic [NUM_SW-1:0]  r_sync1, r_sync2, r_cand, r_sw_db, r_flags;
  logic [c_cnt_w-1:0] r_cnt;

  logic [31:0]        w_bitmask;
  logic [31:0]        w_rdata_mux;
  logic [1:0]         w_wsel, w_rsel;
  logic               w_wr_commit, w_rd_capture, w_db_accept;
  logic [NUM_SW-1:0]  w_flag_set, w_flag_clr;
  logic               w_unused;

  assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign w_wsel       = S_AXI_AWADDR[3:2];
  assign w_rsel       = S_AXI_ARADDR[3:2];
  assign w_wr_commit  = (r_wstate == c_w_ack);
  assign w_rd_capture = (r_rstate == c_r_ack);

  generate
    for (genvar i = 0; i < 4; i++) begin : g_strb
      assign w_bitmask[8*i +: 8] = {8{S_AXI_WSTRB[i]}};
    end
  endgenerate

  // Write channel FSM
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_wstate <= c_w_idle;
    else                r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      c_w_idle: if (S_AXI_AWVALID && S_AXI_WVALID) w_wstate_nxt = c_w_ack;
      c_w_ack:  w_wstate_nxt = c_w_resp;
      c_w_resp: if (S_AXI_BREADY) w_wstate_nxt = c_w_idle;
      default:  w_wstate_nxt = c_w_idle;
    endcase
  end

  always_comb begin
    S_AXI_AWREADY = (r_wstate == c_w_ack);
    S_AXI_WREADY  = (r_wstate == c_w_ack);
    S_AXI_BVALID  = (r_wstate == c_w_resp);
    S_AXI_BRESP   = 2'b00;
  end

  // Read channel FSM
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_rstate <= c_r_idle;
    else                r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      c_r_idle: if (S_AXI_ARVALID) w_rstate_nxt = c_r_ack;
      c_r_ack:  w_rstate_nxt = c_r_data;
      c_r_data: if (S_AXI_RREADY) w_rstate_nxt = c_r_idle;
      default:  w_rstate_nxt = c_r_idle;
    endcase
  end

  always_comb begin
    S_AXI_ARREADY = (r_rstate == c_r_ack);
    S_AXI_RVALID  = (r_rstate == c_r_data);
    S_AXI_RRESP   = 2'b00;
    S_AXI_RDATA   = r_rdata;
  end

  // Software-writable registers
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_led  <= '0;
      r_ctrl <= '0;
      r_scr  <= '0;
    end else if (w_wr_commit) begin
      case (w_wsel)
        2'd0: r_led  <= (r_led & ~w_bitmask[NUM_LED-1:0]) | (S_AXI_WDATA[NUM_LED-1:0] & w_bitmask[NUM_LED-1:0]);
        2'd2: r_ctrl <= (r_ctrl & ~w_bitmask[1:0]) | (S_AXI_WDATA[1:0] & w_bitmask[1:0]);
        2'd3: r_scr  <= (r_scr & ~w_bitmask) | (S_AXI_WDATA & w_bitmask);
        default: ;
      endcase
    end
  end

  // A flag being set on the same edge as its W1C clear stays set.
  assign w_db_accept = (r_sync2 == r_cand) && (r_cnt == c_cnt_max);
  assign w_flag_set  = w_db_accept ? (r_sw_db ^ r_cand) : '0;
  assign w_flag_clr  = (w_wr_commit && (w_wsel == 2'd1)) ?
                       (S_AXI_WDATA[16 +: NUM_SW] & w_bitmask[16 +: NUM_SW]) : '0;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cand  <= '0;
      r_cnt   <= '0;
      r_sw_db <= '0;
      r_flags <= '0;
    end else begin
      r_sync1 <= sw_i;
      r_sync2 <= r_sync1;
      r_flags <= (r_flags & ~w_flag_clr) | w_flag_set;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else if (r_cnt == c_cnt_max) begin
        r_sw_db <= r_cand;
      end else begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

  always_comb begin
    w_rdata_mux = 32'd0;
    case (w_rsel)
      2'd0: w_rdata_mux = 32'(r_led);
      2'd1: w_rdata_mux = 32'(r_sw_db) | (32'(r_flags) << 16);
      2'd2: w_rdata_mux = {30'd0, r_ctrl};
      2'd3: w_rdata_mux = r_scr;
      default: w_rdata_mux = 32'd0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rdata <= '0;
      r_led_o <= '0;
    end else begin
      if (w_rd_capture) r_rdata <= w_rdata_mux;
      r_led_o <= (r_ctrl[0] ? NUM_LED'(r_sw_db) : r_led) ^ {NUM_LED{r_ctrl[1]}};
    end
  end

  assign led_o = r_led_o;

endmodule
`default_nettype wire

// File: tb/tb_switch_led_axil_slave.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_switch_led_axil_slave: randomized self-checking bench with a         |
// | behavioural register/debounce model.  Rev 1.0                          |
// +------------------------------------------------------------------------+
module tb_switch_led_axil_slave;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [3:0]  sw_i = '0;
  logic [3:0]  led_o;

  int checks = 0;
  int errors = 0;

  switch_led_axil_slave #(.DEBOUNCE_CYCLES(D)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .sw_i(sw_i), .led_o(led_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register contents, switch pipeline and a run-length view of debouncing.
  logic [3:0]  m_led = '0, m_db = '0, m_flags = '0, m_s1 = '0, m_s2 = '0, m_last = '0, m_led_o = '0;
  logic [1:0]  m_ctrl = '0;
  logic [31:0] m_scr = '0;
  int          m_run = 1;
  logic        mw_pend = 0;
  logic [3:0]  mw_addr = '0, mw_strb = '0;
  logic [31:0] mw_data = '0;

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return {28'd0, m_led};
      2'd1:    return {12'd0, m_flags, 12'd0, m_db};
      2'd2:    return {30'd0, m_ctrl};
      default: return m_scr;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [3:0]  nxt_led_o, set, clr;
    logic [31:0] bm;
    if (!rst_n) begin
      m_led = '0; m_db = '0; m_flags = '0; m_s1 = '0; m_s2 = '0; m_last = '0;
      m_led_o = '0; m_ctrl = '0; m_scr = '0; m_run = 1; mw_pend = 0;
    end else begin
      nxt_led_o = (m_ctrl[0] ? m_db : m_led) ^ {4{m_ctrl[1]}};
      // a synchronised value is accepted once seen on D+1 consecutive edges
      if (m_s2 == m_last) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_last = m_s2;
        m_run  = 1;
      end
      set = '0;
      if (m_run >= D + 1) begin
        set  = m_db ^ m_s2;
        m_db = m_s2;
      end
      clr = '0;
      if (mw_pend) begin
        for (int i = 0; i < 32; i++) bm[i] = mw_strb[i/8];
        case (mw_addr[3:2])
          2'd0: m_led  = (m_led & ~bm[3:0]) | (mw_data[3:0] & bm[3:0]);
          2'd1: clr    = mw_data[19:16] & bm[19:16];
          2'd2: m_ctrl = (m_ctrl & ~bm[1:0]) | (mw_data[1:0] & bm[1:0]);
          default: m_scr = (m_scr & ~bm) | (mw_data & bm);
        endcase
        mw_pend = 0;
      end
      m_flags = (m_flags & ~clr) | set;
      m_s2    = m_s1;
      m_s1    = sw_i;
      m_led_o = nxt_led_o;
    end
  end

  always @(negedge clk) chk("led_o", {28'd0, led_o}, {28'd0, m_led_o});

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_lead, input int b_delay);
    @(negedge clk);
    awaddr = a; awvalid = 1; wdata = d; wstrb = s; bready = 0;
    for (int i = 0; i < aw_lead; i++) begin
      @(negedge clk);
      chk("awready_wait", {31'd0, awready}, 32'd0);
      chk("wready_wait", {31'd0, wready}, 32'd0);
    end
    wvalid = 1;
    @(negedge clk);
    chk("awready", {31'd0, awready}, 32'd1);
    chk("wready", {31'd0, wready}, 32'd1);
    mw_addr = a; mw_data = d; mw_strb = s; mw_pend = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    chk("bvalid", {31'd0, bvalid}, 32'd1);
    chk("bresp", {30'd0, bresp}, 32'd0);
    for (int i = 0; i < b_delay; i++) begin
      @(negedge clk);
      chk("bvalid_hold", {31'd0, bvalid}, 32'd1);
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    chk("bvalid_drop", {31'd0, bvalid}, 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] a, input int r_delay, output logic [31:0] d);
    logic [31:0] exp;
    @(negedge clk);
    araddr = a; arvalid = 1; rready = 0;
    @(negedge clk);
    chk("arready", {31'd0, arready}, 32'd1);
    exp = m_read(a);
    @(negedge clk);
    arvalid = 0;
    chk("rvalid", {31'd0, rvalid}, 32'd1);
    chk("rresp", {30'd0, rresp}, 32'd0);
    chk("rdata", rdata, exp);
    d = rdata;
    for (int i = 0; i < r_delay; i++) begin
      @(negedge clk);
      chk("rvalid_hold", {31'd0, rvalid}, 32'd1);
      chk("rdata_hold", rdata, exp);
    end
    rready = 1;
    @(negedge clk);
    rready = 0;
    chk("rvalid_drop", {31'd0, rvalid}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    repeat (3) @(negedge clk);
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_arready", {31'd0, arready}, 32'd0);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), 0, rd);
      chk("rst_reg", rd, 32'd0);
    end

    axi_write(4'h0, 32'hA5, 4'hF, 0, 0);
    axi_read(4'h0, 0, rd);
    chk("led_reg", rd, 32'h5);
    chk("led_o_sw", {28'd0, led_o}, 32'h5);

    axi_write(4'hC, 32'hDEADBEEF, 4'hF, 0, 0);
    axi_write(4'hC, 32'h11223344, 4'h2, 0, 0);
    axi_read(4'hC, 0, rd);
    chk("scr_strb", rd, 32'hDEAD33EF);

    sw_i = 4'hA;
    repeat (2) @(negedge clk);
    sw_i = 4'h0;
    repeat (8) @(negedge clk);
    axi_read(4'h4, 0, rd);
    chk("sw_glitch", rd, 32'h0);
    sw_i = 4'hA;
    repeat (8) @(negedge clk);
    axi_read(4'h4, 0, rd);
    chk("sw_db", rd, 32'h000A000A);
    axi_write(4'h4, 32'h000A0000, 4'hF, 0, 0);
    axi_read(4'h4, 0, rd);
    chk("sw_w1c", rd, 32'h0000000A);

    axi_write(4'h8, 32'h1, 4'hF, 0, 0);
    chk("led_follow", {28'd0, led_o}, 32'hA);
    axi_write(4'h8, 32'h3, 4'hF, 0, 0);
    chk("led_invert", {28'd0, led_o}, 32'h5);
    axi_write(4'h8, 32'h0, 4'hF, 0, 0);

    axi_write(4'hC, 32'hCAFEF00D, 4'hF, 3, 5);
    axi_read(4'hC, 5, rd);
    chk("scr_slow", rd, 32'hCAFEF00D);
    fork
      axi_write(4'hC, 32'h12345678, 4'hF, 0, 0);
      axi_read(4'hC, 0, rd);
    join
    chk("rd_pre_write", rd, 32'hCAFEF00D);
    axi_read(4'hC, 0, rd);
    chk("rd_post_write", rd, 32'h12345678);

    for (int it = 0; it < 80; it++) begin
      logic [3:0] a, s;
      logic [31:0] d;
      sw_i = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 8)) @(negedge clk);
      a = 4'($urandom_range(0, 15));
      s = 4'($urandom_range(0, 15));
      d = $urandom;
      if ($urandom_range(0, 1) == 1) axi_write(a, d, s, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      else axi_read(a, int'($urandom_range(0, 3)), rd);
    end

    axi_write(4'h8, 32'h0, 4'hF, 0, 0);
    axi_write(4'h0, 32'h5, 4'hF, 0, 0);
    @(negedge clk);
    awaddr = 4'hC; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    @(negedge clk);
    mw_addr = 4'hC; mw_data = 32'h55; mw_strb = 4'hF; mw_pend = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    chk("pre_rst_bvalid", {31'd0, bvalid}, 32'd1);
    #2 rst_n = 0;
    #1;
    chk("async_bvalid", {31'd0, bvalid}, 32'd0);
    chk("async_led_o", {28'd0, led_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    axi_read(4'h0, 0, rd);
    chk("post_rst_led", rd, 32'd0);
    chk("post_rst_led_o", {28'd0, led_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
